// File: rtl/rr_mux_pkg.sv
// Shared constants and types for the 4-channel round-robin beat multiplexer.
// Used by rr_arb_4 and rr_mux_4x1 (optional packet lock: RR_MUX_4X1_PKT_LOCK_EN).
package rr_mux_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [NUM_CH-1:0] grant_t;
  typedef logic [SEL_W-1:0]  sel_t;

  // One-hot grant to channel index; zero or malformed vectors map to channel 0.
  function automatic sel_t grant_to_idx(input grant_t g);
    sel_t idx;
    case (g)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb_4.sv
// Combinational 4-way round-robin arbiter: searches ptr+1 .. ptr+4 (mod 4).
// While lock is high only lock_ch may be granted.
module rr_arb_4
  import rr_mux_pkg::*;
(
  input  grant_t req,
  input  sel_t   ptr,
  input  logic   lock,
  input  sel_t   lock_ch,
  output grant_t grant
);

  grant_t w_rr;
  grant_t w_lk;
  sel_t   w_c;
  logic   w_hit;
  logic   w_found;

  // Rotating first-set search starting just after the last granted channel.
  always_comb begin
    w_rr    = 4'b0000;
    w_c     = 2'd0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_c       = sel_t'(ptr + sel_t'(i));
      w_hit     = req[w_c] & ~w_found;
      w_rr[w_c] = w_rr[w_c] | w_hit;
      w_found   = w_found | w_hit;
    end
  end

  assign w_lk  = grant_t'({{(NUM_CH-1){1'b0}}, req[lock_ch]}) << lock_ch;
  assign grant = lock ? w_lk : w_rr;

endmodule

// File: rtl/rr_mux_4x1.sv
// 4:1 round-robin beat multiplexer with a single registered output stage.
// Define RR_MUX_4X1_PKT_LOCK_EN to hold arbitration on one channel until in_last.
module rr_mux_4x1
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_last
);

  logic              w_load_en;
  logic              w_xfer;
  logic              w_lock;
  grant_t            w_grant;
  sel_t              w_idx;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_sel_last;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  sel_t              r_out_sel;
  logic              r_out_last;
  sel_t              r_ptr;

  assign w_load_en  = ~r_out_valid | out_ready;
  assign in_ready   = w_load_en ? w_grant : 4'b0000;
  assign w_xfer     = |in_ready;
  assign w_idx      = grant_to_idx(w_grant);
  assign w_sel_data = in_data[int'(w_idx)*DATA_W +: DATA_W];
  assign w_sel_last = in_last[w_idx];

`ifdef RR_MUX_4X1_PKT_LOCK_EN
  logic r_lock;

  // A non-final beat pins arbitration to its channel; the final beat releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock <= 1'b0;
    end else if (w_xfer) begin
      r_lock <= ~w_sel_last;
    end
  end

  assign w_lock = r_lock;
`else
  assign w_lock = 1'b0;
`endif

  rr_arb_4 u_arb (
    .req     (in_valid),
    .ptr     (r_ptr),
    .lock    (w_lock),
    .lock_ch (r_ptr),
    .grant   (w_grant)
  );

  // Output beat register; refills in the same cycle the held beat drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_out_last  <= 1'b0;
    end else if (w_load_en) begin
      r_out_valid <= w_xfer;
      if (w_xfer) begin
        r_out_data <= w_sel_data;
        r_out_sel  <= w_idx;
        r_out_last <= w_sel_last;
      end
    end
  end

  // ptr starts at 3 so channel 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd3;
    end else if (w_xfer) begin
      r_ptr <= w_idx;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_rr_mux_4x1.sv
// Self-checking bench for rr_mux_4x1: directed vector table, reference model with
// scoreboard, random traffic, mid-stream reset, and packet lock when enabled.
module tb_rr_mux_4x1;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    in_valid;
  logic [3:0]    in_ready;
  logic [4*DW-1:0] in_data;
  logic [3:0]    in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_sel;
  logic          out_last;

  always #5 clk = ~clk;

  rr_mux_4x1 #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] d;
    logic [3:0]  lst;
    logic        ordy;
    logic [3:0]  e_ir;
    logic        e_ov;
    logic [1:0]  e_sel;
    logic [7:0]  e_data;
    logic        e_last;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       last;
  } beat_t;

  beat_t sb_q[$];
  int checks   = 0;
  int failures = 0;

  logic [1:0] m_ptr;
  logic       m_ov;
  logic       m_lock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_grant(input logic [3:0] req, input logic [1:0] p, input logic lk);
    logic [3:0] g;
    logic [1:0] c;
    g = 4'b0000;
    if (lk) begin
      if (req[p]) g[p] = 1'b1;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        c = p + 2'(i);
        if (req[c] && g == 4'b0000) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_ptr  = 2'd3;
    m_ov   = 1'b0;
    m_lock = 1'b0;
    sb_q.delete();
  endtask

  // One clock: drive at negedge, check against the model, advance the model.
  task automatic cycle(input logic [3:0] iv, input logic [31:0] d, input logic [3:0] lst, input logic ordy);
    logic [3:0] g;
    logic       ld;
    beat_t      b;
    int         k;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    in_last   = lst;
    out_ready = ordy;
    #1;
    ld = !m_ov || ordy;
    g  = m_grant(iv, m_ptr, m_lock);
    chk("in_ready", in_ready, ld ? g : 4'b0000);
    chk("out_valid", out_valid, m_ov);
    if (out_valid && ordy) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got out beat sel=%0d data=%0h expected none", out_sel, out_data);
      end else begin
        b = sb_q.pop_front();
        chk("sb_data", out_data, b.data);
        chk("sb_sel", out_sel, b.sel);
        chk("sb_last", out_last, b.last);
      end
    end
    if (ld) begin
      if (g != 4'b0000) begin
        k = 0;
        for (int j = 0; j < 4; j++) if (g[j]) k = j;
        b.data = d[k*8 +: 8];
        b.sel  = 2'(k);
        b.last = lst[k];
        sb_q.push_back(b);
        m_ptr = 2'(k);
`ifdef RR_MUX_4X1_PKT_LOCK_EN
        m_lock = !lst[k];
`endif
        m_ov = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 4'b0000;
    in_data   = 32'h0;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_sel", out_sel, 2'd0);
    chk("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] D = 32'h33221100;
  vec_t vecs[16];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            iv       d             lst      ordy  e_ir     e_ov  sel   data   last
    vecs[0]  = '{4'b1111, D,            4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[1]  = '{4'b1111, D,            4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 8'h00, 1'b1};
    vecs[2]  = '{4'b1111, D,            4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 8'h11, 1'b1};
    vecs[3]  = '{4'b1111, D,            4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 8'h22, 1'b1};
    vecs[4]  = '{4'b1111, D,            4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h33, 1'b1};
    vecs[5]  = '{4'b0000, D,            4'b1111, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h00, 1'b1};
    vecs[6]  = '{4'b0000, D,            4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[7]  = '{4'b0100, 32'h5AA5C33C, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[8]  = '{4'b0000, D,            4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 8'hA5, 1'b1};
    vecs[9]  = '{4'b1111, D,            4'b1000, 1'b0, 4'b1000, 1'b0, 2'd0, 8'h00, 1'b0};
    vecs[10] = '{4'b1111, D,            4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b1};
    vecs[11] = '{4'b1111, D,            4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b1};
    vecs[12] = '{4'b1111, D,            4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h33, 1'b1};
    vecs[13] = '{4'b1111, D,            4'b1000, 1'b1, 4'b0001, 1'b1, 2'd3, 8'h33, 1'b1};
    vecs[14] = '{4'b0000, D,            4'b1000, 1'b1, 4'b0000, 1'b1, 2'd0, 8'h00, 1'b0};
    vecs[15] = '{4'b0000, D,            4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00, 1'b0};

    do_reset();

    for (int v = 0; v < 16; v++) begin
      cycle(vecs[v].iv, vecs[v].d, vecs[v].lst, vecs[v].ordy);
      chk($sformatf("vec%0d_in_ready", v), in_ready, vecs[v].e_ir);
      chk($sformatf("vec%0d_out_valid", v), out_valid, vecs[v].e_ov);
      if (vecs[v].e_ov) begin
        chk($sformatf("vec%0d_out_sel", v), out_sel, vecs[v].e_sel);
        chk($sformatf("vec%0d_out_data", v), out_data, vecs[v].e_data);
        chk($sformatf("vec%0d_out_last", v), out_last, vecs[v].e_last);
      end
    end

    // Random traffic with random backpressure, checked by model and scoreboard.
    for (int n = 0; n < 300; n++) begin
      cycle(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) != 0));
    end
    repeat (3) cycle(4'b0000, 32'h0, 4'b0000, 1'b1);
    chk("sb_empty", sb_q.size(), 0);

    // Reset asserted while a beat is held under backpressure.
    do_reset();
    cycle(4'b1111, D, 4'b1111, 1'b1);
    cycle(4'b1111, D, 4'b1111, 1'b0);
    chk("pre_rst_out_valid", out_valid, 1'b1);
    @(negedge clk);
    in_valid = 4'b0000;
    rst_n    = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_out_sel", out_sel, 2'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, D, 4'b1111, 1'b1);
    chk("post_rst_grant", in_ready, 4'b0001);
    cycle(4'b0000, D, 4'b1111, 1'b1);
    chk("post_rst_out_sel", out_sel, 2'd0);
    chk("post_rst_out_data", out_data, 8'h00);

`ifdef RR_MUX_4X1_PKT_LOCK_EN
    // Channel 1 holds the arbiter across a three-beat packet, then ch3 follows.
    begin
      logic [3:0]  l_iv[6];
      logic [31:0] l_d[6];
      logic [3:0]  l_lst[6];
      logic [3:0]  l_ir[6];
      logic [7:0]  l_od[6];
      logic [1:0]  l_os[6];
      do_reset();
      l_iv = '{4'b0001, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0000};
      l_d  = '{32'h0000000F, 32'h03001001, 32'h03001101, 32'h03001201, 32'h03001201, 32'h0};
      l_lst = '{4'b0001, 4'b1001, 4'b1001, 4'b1011, 4'b1011, 4'b0000};
      l_ir = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
      l_od = '{8'h00, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h03};
      l_os = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
      for (int s = 0; s < 6; s++) begin
        cycle(l_iv[s], l_d[s], l_lst[s], 1'b1);
        chk($sformatf("lock%0d_in_ready", s), in_ready, l_ir[s]);
        if (s > 0) begin
          chk($sformatf("lock%0d_out_data", s), out_data, l_od[s]);
          chk($sformatf("lock%0d_out_sel", s), out_sel, l_os[s]);
        end
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
